iob_pcie_tx_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one RIFFA-style PCIe TX channel among NREQ

---
 rtl/iob_pcie_tx_arb.sv | 179 +++++++++++++++++
 tb/tb_iob_pcie_tx_arb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_pcie_tx_arb.sv
// iob_pcie_tx_arb: round-robin sequencer that shares one RIFFA-style PCIe TX
// channel among NREQ requesters. One requester owns the channel per
// transaction; its beats are forwarded until the latched word length is covered.
module iob_pcie_tx_arb #(
  parameter int NREQ             = 3,
  parameter int DATA_W           = 32,
  parameter int C_PCI_DATA_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [NREQ-1:0]                  req_i,
  input  logic [NREQ*DATA_W-1:0]           len_i,
  input  logic [NREQ*C_PCI_DATA_WIDTH-1:0] data_i,
  input  logic [NREQ-1:0]                  data_valid_i,
  output logic [NREQ-1:0]                  data_ren_o,
  output logic [NREQ-1:0]                  grant_o,
  output logic [NREQ-1:0]                  done_o,
  output logic                             tx_clk_o,
  output logic                             tx_o,
  input  logic                             tx_ack_i,
  output logic                             tx_last_o,
  output logic [DATA_W-1:0]                tx_len_o,
  output logic [DATA_W-2:0]                tx_off_o,
  output logic [C_PCI_DATA_WIDTH-1:0]      tx_data_o,
  output logic                             tx_data_valid_o,
  input  logic                             tx_data_ren_i
);

  localparam int WPB   = C_PCI_DATA_WIDTH / DATA_W;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            nextState_s;
  logic [NREQ-1:0]   grant_r;
  logic [NREQ-1:0]   done_r;
  logic              tx_r;
  logic [IDX_W-1:0]  owner_r;
  logic [IDX_W-1:0]  ptr_r;
  logic [DATA_W-1:0] len_r;
  logic [DATA_W-1:0] cnt_r;
  logic [DATA_W-1:0] cntNext_s;
  logic [IDX_W:0]    pickRes_s;
  logic              pickValid_s;
  logic [IDX_W-1:0]  pick_s;
  logic              accept_s;
  logic              lastBeat_s;

  // First asserted request at or after the pointer, wrapping; MSB flags a hit.
  function automatic logic [IDX_W:0] rrPick(input logic [NREQ-1:0] req,
                                            input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (req[idx]) begin
        res = {1'b1, IDX_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pickRes_s   = rrPick(req_i, ptr_r);
  assign pickValid_s = pickRes_s[IDX_W];
  assign pick_s      = pickRes_s[IDX_W-1:0];

  // Count arithmetic stays DATA_W wide; a beat always carries WPB words.
  assign cntNext_s  = cnt_r + DATA_W'(WPB);
  assign accept_s   = (state_r == DATA) && data_valid_i[owner_r] && tx_data_ren_i;
  assign lastBeat_s = accept_s && (cntNext_s >= len_r);

  assign tx_clk_o  = clk;
  assign tx_last_o = 1'b1;
  assign tx_off_o  = '0;
  assign tx_o      = tx_r;
  assign grant_o   = grant_r;
  assign done_o    = done_r;
  assign tx_len_o  = len_r;

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decode; the owner is chosen only while idle.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (pickValid_s) nextState_s = REQ;
        else             nextState_s = IDLE;
      end
      REQ: begin
        if (tx_ack_i) begin
          if (len_r == '0) nextState_s = DONE;
          else             nextState_s = DATA;
        end else begin
          nextState_s = REQ;
        end
      end
      DATA: begin
        if (lastBeat_s) nextState_s = DONE;
        else            nextState_s = DATA;
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Data-path muxing from the owner; nothing leaks out outside DATA.
  always_comb begin
    data_ren_o      = '0;
    tx_data_o       = '0;
    tx_data_valid_o = 1'b0;
    if (state_r == DATA) begin
      tx_data_o       = data_i[owner_r*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH];
      tx_data_valid_o = data_valid_i[owner_r];
      if (accept_s) begin
        data_ren_o[owner_r] = 1'b1;
      end else begin
        data_ren_o = '0;
      end
    end else begin
      data_ren_o      = '0;
      tx_data_o       = '0;
      tx_data_valid_o = 1'b0;
    end
  end

  // Transaction registers: grant/length latch, word count, done pulse, pointer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      grant_r <= '0;
      done_r  <= '0;
      tx_r    <= 1'b0;
      owner_r <= '0;
      ptr_r   <= '0;
      len_r   <= '0;
      cnt_r   <= '0;
    end else begin
      tx_r   <= (nextState_s == REQ) || (nextState_s == DATA);
      done_r <= (nextState_s == DONE) ? grant_r : '0;
      if ((state_r == IDLE) && pickValid_s) begin
        grant_r <= NREQ'(1) << pick_s;
        owner_r <= pick_s;
        len_r   <= len_i[pick_s*DATA_W +: DATA_W];
      end else if (nextState_s == DONE) begin
        grant_r <= '0;
      end
      if ((state_r == REQ) && tx_ack_i) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        cnt_r <= cntNext_s;
      end
      if (state_r == DONE) begin
        ptr_r <= (owner_r == IDX_W'(NREQ - 1)) ? '0 : owner_r + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_iob_pcie_tx_arb.sv
// Scoreboard bench for iob_pcie_tx_arb: stimulus pushes expected grants,
// beats and done pulses; a negedge monitor pops and compares on DUT events.
module tb_iob_pcie_tx_arb;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int CW   = 64;

  logic               clk = 1'b0;
  logic               arst_n = 1'b0;
  logic [NREQ-1:0]    req_i = '0;
  logic [NREQ*DW-1:0] len_i = '0;
  logic [NREQ*CW-1:0] data_i = '0;
  logic [NREQ-1:0]    data_valid_i = '0;
  logic [NREQ-1:0]    data_ren_o;
  logic [NREQ-1:0]    grant_o;
  logic [NREQ-1:0]    done_o;
  logic               tx_clk_o;
  logic               tx_o;
  logic               tx_ack_i = 1'b0;
  logic               tx_last_o;
  logic [DW-1:0]      tx_len_o;
  logic [DW-2:0]      tx_off_o;
  logic [CW-1:0]      tx_data_o;
  logic               tx_data_valid_o;
  logic               tx_data_ren_i = 1'b0;

  iob_pcie_tx_arb #(.NREQ(NREQ), .DATA_W(DW), .C_PCI_DATA_WIDTH(CW)) dut (
    .clk(clk), .arst_n(arst_n), .req_i(req_i), .len_i(len_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_ren_o(data_ren_o), .grant_o(grant_o),
    .done_o(done_o), .tx_clk_o(tx_clk_o), .tx_o(tx_o), .tx_ack_i(tx_ack_i),
    .tx_last_o(tx_last_o), .tx_len_o(tx_len_o), .tx_off_o(tx_off_o),
    .tx_data_o(tx_data_o), .tx_data_valid_o(tx_data_valid_o),
    .tx_data_ren_i(tx_data_ren_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]   data;
    logic [NREQ-1:0] ren;
    bit              last;
  } beat_t;

  typedef struct {
    logic [NREQ-1:0] g;
    logic [DW-1:0]   len;
  } txn_t;

  beat_t           expBeat[$];
  txn_t            expTxn[$];
  logic [NREQ-1:0] expDone[$];

  int          nCmp = 0;
  int          nErr = 0;
  int          doneCnt = 0;
  int          acceptCnt = 0;
  int          cyc = 0;
  int          ackDly = 1;
  int          ackCnt = 0;
  bit          armed = 1'b1;
  int          vldMode = 0;
  int          renMode = 0;
  bit          vldNow = 1'b1;
  bit          txPrev = 1'b0;
  bit          lastPrev = 1'b0;
  logic [31:0] beatIdx[NREQ];
  logic [31:0] expIdx[NREQ];

  function automatic logic [CW-1:0] beatData(input int r, input logic [31:0] idx);
    return {32'hA000_0000 | 32'(r), idx};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectTxn(input int r, input int len, input int nBeats);
    txn_t  t;
    beat_t b;
    t.g    = '0;
    t.g[r] = 1'b1;
    t.len  = 32'(len);
    expTxn.push_back(t);
    for (int k = 0; k < nBeats; k++) begin
      b.data = beatData(r, expIdx[r]);
      b.ren  = t.g;
      b.last = (k == nBeats - 1);
      expIdx[r] = expIdx[r] + 32'd1;
      expBeat.push_back(b);
    end
    expDone.push_back(t.g);
  endtask

  task automatic waitDone(input int target, input int budget, input string name);
    int n = 0;
    while (doneCnt < target && n < budget) begin
      @(posedge clk); #3;
      n++;
    end
    if (doneCnt < target) begin
      nCmp++;
      nErr++;
      $display("FAIL %s: timeout, done pulses %0d expected %0d", name, doneCnt, target);
    end
  endtask

  task automatic qEmpty(input string name);
    check(name, 64'(expBeat.size() + expTxn.size() + expDone.size()), 64'd0);
  endtask

  task automatic doReset();
    @(posedge clk); #3;
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    for (int i = 0; i < NREQ; i++) expIdx[i] = 32'd0;
    arst_n = 1'b1;
    @(posedge clk); #3;
  endtask

  // Source model and channel-side driver: data/valid/ren/ack after each edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    vldNow        = (vldMode == 0) ? 1'b1 : ((cyc % 3) != 0);
    data_valid_i  = {NREQ{vldNow}};
    tx_data_ren_i = (renMode == 0) ? 1'b1 : cyc[0];
    for (int i = 0; i < NREQ; i++) data_i[i*CW +: CW] = beatData(i, beatIdx[i]);
    tx_ack_i = 1'b0;
    if (!tx_o) begin
      armed  = 1'b1;
      ackCnt = 0;
    end else if (armed) begin
      if (ackCnt >= ackDly) begin
        tx_ack_i = 1'b1;
        armed    = 1'b0;
      end else begin
        ackCnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on grant, beat and done events.
  always @(negedge clk) begin
    txn_t  t;
    beat_t b;
    if (!arst_n) begin
      for (int i = 0; i < NREQ; i++) beatIdx[i] = 32'd0;
      txPrev   = 1'b0;
      lastPrev = 1'b0;
      expBeat.delete();
      expTxn.delete();
      expDone.delete();
    end else begin
      if (tx_o && !txPrev) begin
        if (expTxn.size() == 0) begin
          check("unexpected_grant", 64'(grant_o), 64'd0);
        end else begin
          t = expTxn.pop_front();
          check("grant", 64'(grant_o), 64'(t.g));
          check("tx_len", 64'(tx_len_o), 64'(t.len));
        end
      end
      if (lastPrev) check("tx_fall", 64'(tx_o), 64'd0);
      lastPrev = 1'b0;
      if (tx_data_valid_o && !vldNow) check("valid_gap", 64'(tx_data_valid_o), 64'd0);
      if (tx_data_valid_o && tx_data_ren_i) begin
        acceptCnt++;
        if (expBeat.size() == 0) begin
          check("stray_beat", 64'(tx_data_valid_o), 64'd0);
        end else begin
          b = expBeat.pop_front();
          check("beat_data", tx_data_o, b.data);
          check("beat_ren", 64'(data_ren_o), 64'(b.ren));
          lastPrev = b.last;
        end
      end else begin
        if (data_ren_o != '0) check("ren_idle", 64'(data_ren_o), 64'd0);
        if (tx_data_valid_o && expBeat.size() == 0)
          check("stray_valid", 64'(tx_data_valid_o), 64'd0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (data_ren_o[i]) beatIdx[i] = beatIdx[i] + 32'd1;
      end
      if (done_o != '0) begin
        doneCnt++;
        if (expDone.size() == 0) begin
          check("stray_done", 64'(done_o), 64'd0);
        end else begin
          check("done", 64'(done_o), 64'(expDone.pop_front()));
          check("grant_in_done", 64'(grant_o), 64'd0);
        end
      end
      txPrev = tx_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, time %0t expected below 2000000", $time);
    $fatal(1);
  end

  initial begin
    int base;
    for (int i = 0; i < NREQ; i++) expIdx[i] = 32'd0;
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_tx", 64'(tx_o), 64'd0);
    check("rst_len", 64'(tx_len_o), 64'd0);
    check("rst_ren", 64'(data_ren_o), 64'd0);
    check("rst_dvalid", 64'(tx_data_valid_o), 64'd0);
    check("last_const", 64'(tx_last_o), 64'd1);
    check("off_const", 64'(tx_off_o), 64'd0);
    arst_n = 1'b1;
    @(posedge clk); #3;

    // 1: single requester, slow ack, two beats.
    ackDly = 3;
    len_i[0*DW +: DW] = 32'd4;
    req_i = 3'b001;
    expectTxn(0, 4, 2);
    waitDone(1, 100, "t1_done");
    req_i  = 3'b000;
    ackDly = 1;
    qEmpty("t1_queue");

    // 2: all three requesting from pointer 0.
    doReset();
    base = doneCnt;
    len_i = {32'd2, 32'd2, 32'd2};
    req_i = 3'b111;
    expectTxn(0, 2, 1);
    expectTxn(1, 2, 1);
    expectTxn(2, 2, 1);
    expectTxn(0, 2, 1);
    waitDone(base + 4, 200, "t2_done");
    req_i = 3'b000;
    qEmpty("t2_queue");

    // 3: zero-length transaction, no data phase.
    base = doneCnt;
    len_i[1*DW +: DW] = 32'd0;
    req_i = 3'b010;
    expectTxn(1, 0, 0);
    waitDone(base + 1, 100, "t3_done");
    req_i = 3'b000;
    qEmpty("t3_queue");

    // 4: valid gaps and toggling ren, three beats.
    base    = doneCnt;
    vldMode = 1;
    renMode = 1;
    len_i[0*DW +: DW] = 32'd6;
    req_i = 3'b001;
    expectTxn(0, 6, 3);
    waitDone(base + 1, 200, "t4_done");
    req_i   = 3'b000;
    vldMode = 0;
    renMode = 0;
    qEmpty("t4_queue");

    // 5: odd length rounds up to whole beats.
    base = doneCnt;
    len_i[0*DW +: DW] = 32'd5;
    req_i = 3'b001;
    expectTxn(0, 5, 3);
    waitDone(base + 1, 200, "t5_done");
    req_i = 3'b000;
    qEmpty("t5_queue");

    // 6: reset in the middle of a four-beat transfer.
    base    = acceptCnt;
    renMode = 1;
    len_i[0*DW +: DW] = 32'd8;
    req_i = 3'b001;
    expectTxn(0, 8, 4);
    for (int n = 0; n < 100 && acceptCnt < base + 1; n++) begin
      @(posedge clk); #3;
    end
    check("t6_first_beat", 64'(acceptCnt - base), 64'd1);
    arst_n = 1'b0;
    req_i  = 3'b000;
    #1;
    check("t6_rst_tx", 64'(tx_o), 64'd0);
    check("t6_rst_grant", 64'(grant_o), 64'd0);
    check("t6_rst_done", 64'(done_o), 64'd0);
    check("t6_rst_ren", 64'(data_ren_o), 64'd0);
    check("t6_rst_dvalid", 64'(tx_data_valid_o), 64'd0);
    check("t6_rst_data", tx_data_o, 64'd0);
    check("t6_rst_len", 64'(tx_len_o), 64'd0);
    renMode = 0;
    repeat (2) @(posedge clk);
    #3;
    for (int i = 0; i < NREQ; i++) expIdx[i] = 32'd0;
    arst_n = 1'b1;
    @(posedge clk); #3;
    base = doneCnt;
    len_i[2*DW +: DW] = 32'd2;
    req_i = 3'b100;
    expectTxn(2, 2, 1);
    waitDone(base + 1, 100, "t6_done");
    req_i = 3'b000;
    repeat (6) @(posedge clk);
    #3;
    qEmpty("t6_queue");
    check("t6_done_count", 64'(doneCnt - base), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
